// File: rtl/rom_sdram_arbiter.sv
// Arbiter between ROM reads, download writes and refresh for a single SDRAM controller port.
// One command is in flight at a time; refresh outranks writes, and writes outrank reads until a burst limit is reached.
module rom_sdram_arbiter #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned WR_BURST_MAX = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              MEM_CLK,
  input  logic              RESET_N,
  input  logic              DL_WR,
  input  logic [ADDR_W-1:0] DL_ADDR,
  input  logic [15:0]       DL_DATA,
  output logic              DL_BUSY,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  input  logic              RD_WORD,
  output logic [15:0]       RD_Q,
  output logic              RD_VALID,
  input  logic              REF_REQ,
  output logic              MEM_REQ,
  output logic [1:0]        MEM_CMD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DIN,
  output logic              MEM_WORD,
  input  logic              MEM_ACK,
  input  logic              MEM_DONE,
  input  logic [15:0]       MEM_DOUT,
  output logic              ERR
);

  localparam int unsigned BC_W = $clog2(WR_BURST_MAX + 2);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2,
    CMD_REFRESH = 2'd3
  } cmd_e;

  state_e              state_q, state_d;
  cmd_e                cmd_q, cmd_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic                word_q, word_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [15:0]         wb_data_q, wb_data_d;
  logic                ref_pend_q, ref_pend_d;
  logic                last_valid_q, last_valid_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                last_word_q, last_word_d;
  logic [15:0]         rd_q_q, rd_q_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  logic rd_pend;
  logic complete;
  logic ref_any;
  logic wr_any;
  logic burst_full;

  always_comb begin
    rd_pend    = RD_REQ && (!last_valid_q || (RD_ADDR != last_addr_q) || (RD_WORD != last_word_q));
    complete   = ((state_q == S_WAIT) && MEM_DONE) || ((state_q == S_ISSUE) && MEM_ACK && MEM_DONE);
    // Same-cycle REF_REQ / DL_WR are visible to selection so simultaneous requests keep their priority order.
    ref_any    = ref_pend_q || REF_REQ;
    wr_any     = wb_valid_q || DL_WR;
    burst_full = (burst_cnt_q == BC_W'(WR_BURST_MAX));

    state_d      = state_q;
    cmd_d        = cmd_q;
    req_d        = req_q;
    addr_d       = addr_q;
    din_d        = din_q;
    word_d       = word_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    ref_pend_d   = ref_pend_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    last_word_d  = last_word_q;
    rd_q_d       = rd_q_q;
    rd_valid_d   = 1'b0;
    err_d        = err_q;
    burst_cnt_d  = burst_cnt_q;
    to_cnt_d     = to_cnt_q;

    if (complete) begin
      case (cmd_q)
        CMD_READ: begin
          rd_q_d       = MEM_DOUT;
          rd_valid_d   = 1'b1;
          last_valid_d = 1'b1;
          last_addr_d  = addr_q;
          last_word_d  = word_q;
        end
        CMD_WRITE:   wb_valid_d = 1'b0;
        CMD_REFRESH: ref_pend_d = 1'b0;
        default: ;
      endcase
    end

    if (DL_WR) begin
      if (!wb_valid_q || (complete && (cmd_q == CMD_WRITE))) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = DL_ADDR;
        wb_data_d  = DL_DATA;
      end else begin
        err_d = 1'b1;
      end
    end

    if (REF_REQ) begin
      ref_pend_d = 1'b1;
    end

    if (!RD_REQ) begin
      burst_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (ref_any) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          cmd_d   = CMD_REFRESH;
          addr_d  = '0;
          din_d   = '0;
          word_d  = 1'b0;
        end else if (wr_any && !(rd_pend && burst_full)) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          cmd_d   = CMD_WRITE;
          addr_d  = wb_valid_q ? wb_addr_q : DL_ADDR;
          din_d   = wb_valid_q ? wb_data_q : DL_DATA;
          word_d  = 1'b1;
          if (rd_pend) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (rd_pend) begin
          state_d     = S_ISSUE;
          req_d       = 1'b1;
          cmd_d       = CMD_READ;
          addr_d      = RD_ADDR;
          din_d       = '0;
          word_d      = RD_WORD;
          burst_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (MEM_ACK) begin
          req_d    = 1'b0;
          to_cnt_d = '0;
          if (MEM_DONE) begin
            state_d = S_IDLE;
            cmd_d   = CMD_NONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (MEM_DONE) begin
          state_d = S_IDLE;
          cmd_d   = CMD_NONE;
        end else if (to_cnt_q >= TO_W'(TIMEOUT)) begin
          // Abort leaves the source's pending flag untouched, so it is simply reselected.
          state_d = S_IDLE;
          cmd_d   = CMD_NONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cmd_d   = CMD_NONE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cmd_q        <= CMD_NONE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      word_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      ref_pend_q   <= 1'b0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      last_word_q  <= 1'b0;
      rd_q_q       <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      burst_cnt_q  <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      word_q       <= word_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      ref_pend_q   <= ref_pend_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      last_word_q  <= last_word_d;
      rd_q_q       <= rd_q_d;
      rd_valid_q   <= rd_valid_d;
      err_q        <= err_d;
      burst_cnt_q  <= burst_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign DL_BUSY  = wb_valid_q;
  assign RD_Q     = rd_q_q;
  assign RD_VALID = rd_valid_q;
  assign MEM_REQ  = req_q;
  assign MEM_CMD  = cmd_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DIN  = din_q;
  assign MEM_WORD = word_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_rom_sdram_arbiter.sv
// Directed bench for rom_sdram_arbiter with a behavioural SDRAM controller that logs every command it accepts.
module tb_rom_sdram_arbiter;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [15:0]   dl_data;
  logic          dl_busy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_word;
  logic [15:0]   rd_q;
  logic          rd_valid;
  logic          ref_req;
  logic          mem_req;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_word;
  logic          mem_ack;
  logic          mem_done;
  logic [15:0]   mem_dout;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [1:0]    log_cmd  [0:63];
  logic [AW-1:0] log_addr [0:63];
  logic [15:0]   log_din  [0:63];
  logic          log_word [0:63];
  int n_log     = 0;
  int lat       = 2;
  bit hold_done = 1'b0;
  int rv_cnt    = 0;

  always #5 clk = ~clk;

  rom_sdram_arbiter #(
    .ADDR_W(AW),
    .WR_BURST_MAX(4),
    .TIMEOUT(255)
  ) dut (
    .MEM_CLK(clk),
    .RESET_N(rst_n),
    .DL_WR(dl_wr),
    .DL_ADDR(dl_addr),
    .DL_DATA(dl_data),
    .DL_BUSY(dl_busy),
    .RD_REQ(rd_req),
    .RD_ADDR(rd_addr),
    .RD_WORD(rd_word),
    .RD_Q(rd_q),
    .RD_VALID(rd_valid),
    .REF_REQ(ref_req),
    .MEM_REQ(mem_req),
    .MEM_CMD(mem_cmd),
    .MEM_ADDR(mem_addr),
    .MEM_DIN(mem_din),
    .MEM_WORD(mem_word),
    .MEM_ACK(mem_ack),
    .MEM_DONE(mem_done),
    .MEM_DOUT(mem_dout),
    .ERR(err)
  );

  // Controller model: ack one cycle after MEM_REQ is seen, done 'lat' cycles later, read data = addr[15:0] ^ 0x5A5A.
  initial begin
    int cnt;
    bit busy;
    logic [AW-1:0] a;
    mem_ack = 1'b0; mem_done = 1'b0; mem_dout = '0;
    busy = 1'b0; cnt = 0; a = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_done = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          busy = 1'b0;
          if (!hold_done) begin
            mem_done = 1'b1;
            mem_dout = a[15:0] ^ 16'h5A5A;
          end
        end
      end else if (mem_req) begin
        if (n_log < 64) begin
          log_cmd[n_log]  = mem_cmd;
          log_addr[n_log] = mem_addr;
          log_din[n_log]  = mem_din;
          log_word[n_log] = mem_word;
        end
        n_log++;
        a = mem_addr;
        mem_ack = 1'b1;
        busy = 1'b1;
        cnt = lat;
      end
    end
  end

  always @(negedge clk) if (rd_valid === 1'b1) rv_cnt++;

  task automatic do_reset();
    rst_n = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_word = 1'b0; ref_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_log(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_log >= target && mem_cmd == 2'd0 && !mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0h exp 0", mem_req); end
    checks++; if (mem_cmd !== 2'd0) begin errors++; $display("FAIL reset_mem_cmd got %0h exp 0", mem_cmd); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0h exp 0", rd_valid); end
    checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL reset_dl_busy got %0h exp 0", dl_busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err); end
    checks++; if (rd_q !== 16'h0000) begin errors++; $display("FAIL reset_rd_q got %0h exp 0", rd_q); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (mem_din !== 16'h0) begin errors++; $display("FAIL reset_mem_din got %0h exp 0", mem_din); end
  endtask

  task automatic test_priority();
    int base; int rv0; bit ok;
    base = n_log; rv0 = rv_cnt;
    ref_req = 1'b1; dl_wr = 1'b1; dl_addr = 24'h000010; dl_data = 16'hBEEF;
    rd_req = 1'b1; rd_addr = 24'h000020; rd_word = 1'b1;
    @(negedge clk);
    ref_req = 1'b0; dl_wr = 1'b0;
    wait_log(base + 3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got %0d cmds exp %0d", n_log - base, 3); end
    checks++; if (log_cmd[base] !== 2'd3) begin errors++; $display("FAIL prio_cmd0 got %0h exp 3", log_cmd[base]); end
    checks++; if (log_cmd[base+1] !== 2'd2) begin errors++; $display("FAIL prio_cmd1 got %0h exp 2", log_cmd[base+1]); end
    checks++; if (log_addr[base+1] !== 24'h000010 || log_din[base+1] !== 16'hBEEF) begin
      errors++; $display("FAIL prio_wr_payload got %0h/%0h exp 10/beef", log_addr[base+1], log_din[base+1]); end
    checks++; if (log_cmd[base+2] !== 2'd1) begin errors++; $display("FAIL prio_cmd2 got %0h exp 1", log_cmd[base+2]); end
    checks++; if (log_addr[base+2] !== 24'h000020 || log_word[base+2] !== 1'b1) begin
      errors++; $display("FAIL prio_rd_payload got %0h/%0h exp 20/1", log_addr[base+2], log_word[base+2]); end
    checks++; if (rd_q !== 16'h5A7A) begin errors++; $display("FAIL prio_rd_q got %0h exp 5a7a", rd_q); end
    repeat (10) @(negedge clk);
    checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("FAIL prio_rd_valid_cnt got %0d exp 1", rv_cnt - rv0); end
    checks++; if (n_log - base !== 3) begin errors++; $display("FAIL prio_no_extra got %0d exp 3", n_log - base); end
    rd_req = 1'b0;
  endtask

  task automatic test_burst();
    int base; int sent; bit done;
    logic [1:0] exp_cmd [0:5];
    exp_cmd[0] = 2'd2; exp_cmd[1] = 2'd2; exp_cmd[2] = 2'd2;
    exp_cmd[3] = 2'd2; exp_cmd[4] = 2'd1; exp_cmd[5] = 2'd2;
    base = n_log; sent = 0; done = 1'b0;
    rd_addr = 24'h000100; rd_word = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      dl_wr = 1'b0;
      if (i == 0) rd_req = 1'b1;
      if (!dl_busy && sent < 5) begin
        dl_wr = 1'b1; dl_addr = 24'h000200 + 24'(sent * 4); dl_data = 16'h1000 + 16'(sent);
        sent++;
      end
      if (n_log >= base + 6 && mem_cmd == 2'd0 && !mem_req && !dl_busy) begin
        done = 1'b1;
        break;
      end
    end
    dl_wr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (!done) begin errors++; $display("FAIL burst_timeout got %0d cmds exp 6", n_log - base); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (log_cmd[base+k] !== exp_cmd[k]) begin
        errors++; $display("FAIL burst_cmd%0d got %0h exp %0h", k, log_cmd[base+k], exp_cmd[k]); end
    end
    checks++; if (log_addr[base+4] !== 24'h000100) begin errors++; $display("FAIL burst_rd_addr got %0h exp 100", log_addr[base+4]); end
    checks++; if (log_addr[base+5] !== 24'h000210 || log_din[base+5] !== 16'h1004) begin
      errors++; $display("FAIL burst_w5 got %0h/%0h exp 210/1004", log_addr[base+5], log_din[base+5]); end
    checks++; if (rd_q !== 16'h5B5A) begin errors++; $display("FAIL burst_rd_q got %0h exp 5b5a", rd_q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL burst_err got %0h exp 0", err); end
    rd_req = 1'b0;
  endtask

  task automatic test_read_hit();
    int base; int rv0; bit ok;
    base = n_log; rv0 = rv_cnt;
    rd_addr = 24'h000300; rd_word = 1'b0; rd_req = 1'b1;
    wait_log(base + 1, 100, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok || n_log - base !== 1) begin errors++; $display("FAIL hit_one_cmd got %0d exp 1", n_log - base); end
    checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("FAIL hit_one_valid got %0d exp 1", rv_cnt - rv0); end
    checks++; if (log_addr[base] !== 24'h000300 || log_word[base] !== 1'b0) begin
      errors++; $display("FAIL hit_payload got %0h/%0h exp 300/0", log_addr[base], log_word[base]); end
    checks++; if (rd_q !== 16'h595A) begin errors++; $display("FAIL hit_rd_q got %0h exp 595a", rd_q); end
    rd_word = 1'b1;
    wait_log(base + 2, 100, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok || n_log - base !== 2) begin errors++; $display("FAIL hit_width_change got %0d exp 2", n_log - base); end
    checks++; if (log_word[base+1] !== 1'b1) begin errors++; $display("FAIL hit_word got %0h exp 1", log_word[base+1]); end
    checks++; if (rv_cnt - rv0 !== 2) begin errors++; $display("FAIL hit_valid2 got %0d exp 2", rv_cnt - rv0); end
    rd_req = 1'b0;
  endtask

  task automatic test_overflow();
    int base; bit ok;
    base = n_log;
    dl_wr = 1'b1; dl_addr = 24'h000040; dl_data = 16'h1111;
    @(negedge clk);
    checks++; if (dl_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %0h exp 1", dl_busy); end
    dl_addr = 24'h000044; dl_data = 16'h2222;
    @(negedge clk);
    dl_wr = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0h exp 1", err); end
    wait_log(base + 1, 100, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok || n_log - base !== 1) begin errors++; $display("FAIL ovf_cmds got %0d exp 1", n_log - base); end
    checks++; if (log_addr[base] !== 24'h000040 || log_din[base] !== 16'h1111) begin
      errors++; $display("FAIL ovf_payload got %0h/%0h exp 40/1111", log_addr[base], log_din[base]); end
    checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_free got %0h exp 0", dl_busy); end
  endtask

  task automatic test_timeout();
    int base; int rv0; int k; bit ok; bit seen;
    do_reset();
    base = n_log; rv0 = rv_cnt; seen = 1'b0;
    hold_done = 1'b1;
    rd_addr = 24'h000500; rd_word = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_log == base + 1 && !mem_req) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || err !== 1'b0) begin errors++; $display("FAIL to_enter_wait got %0h err %0h exp 1/0", seen, err); end
    k = 0;
    while (err !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    hold_done = 1'b0;
    checks++; if (k !== 256) begin errors++; $display("FAIL to_cycles got %0d exp 256", k); end
    wait_log(base + 2, 100, ok);
    checks++; if (!ok || log_cmd[base+1] !== 2'd1 || log_addr[base+1] !== 24'h000500) begin
      errors++; $display("FAIL to_reissue got %0h/%0h exp 1/500", log_cmd[base+1], log_addr[base+1]); end
    checks++; if (rd_q !== 16'h5F5A) begin errors++; $display("FAIL to_rd_q got %0h exp 5f5a", rd_q); end
    checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("FAIL to_valid got %0d exp 1", rv_cnt - rv0); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %0h exp 1", err); end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int base; int rv0; int reqs; bit seen;
    do_reset();
    lat = 10;
    base = n_log; rv0 = rv_cnt; reqs = 0; seen = 1'b0;
    rd_addr = 24'h000600; rd_word = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_log == base + 1 && !mem_req) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    rst_n = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    lat = 2;
    checks++; if (!seen) begin errors++; $display("FAIL rw_enter_wait got 0 exp 1"); end
    checks++; if (rv_cnt - rv0 !== 0) begin errors++; $display("FAIL rw_no_valid got %0d exp 0", rv_cnt - rv0); end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL rw_no_req got %0d exp 0", reqs); end
    checks++; if (rd_q !== 16'h0 || err !== 1'b0 || dl_busy !== 1'b0) begin
      errors++; $display("FAIL rw_outputs got %0h/%0h/%0h exp 0/0/0", rd_q, err, dl_busy); end
    checks++; if (mem_cmd !== 2'd0 || mem_addr !== 24'h0) begin
      errors++; $display("FAIL rw_mem_out got %0h/%0h exp 0/0", mem_cmd, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_burst();
    test_read_hit();
    test_overflow();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
